// File: rtl/pulse_freq_meter.sv
// Gated edge counter: counts rising edges of an asynchronous pulse train over GATE_CYCLES clocks.
// Optional macro PERIOD_MEAS_EN adds an edge-to-edge period measurement (period_cyc/period_valid).
`timescale 1ns/1ps

module pulse_freq_meter #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int CNT_W       = 27,
    parameter int GATE_W      = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] freq_cnt,
    output logic             meas_valid,
    output logic             ovf
`ifdef PERIOD_MEAS_EN
    ,
    output logic [31:0]      period_cyc,
    output logic             period_valid
`endif
);

    typedef enum logic {IDLE, COUNT} state_t;

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_t            state;
    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic              sat;
    logic              s1, s2, s3;
    logic              pulse_edge;
    logic              cnt_full;

    // Two flops resynchronise pulse_in; the third gives a one-cycle rising-edge strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pulse_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse_edge = s2 & ~s3;
    assign cnt_full   = (edge_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat        <= 1'b0;
            freq_cnt   <= '0;
            meas_valid <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                IDLE: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    sat      <= 1'b0;
                    if (en) begin
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (gate_cnt == GATE_LAST) begin
                        // An edge on the final gate cycle still belongs to the ending window.
                        freq_cnt   <= (pulse_edge && !cnt_full) ? edge_cnt + CNT_ONE : edge_cnt;
                        ovf        <= sat | (pulse_edge & cnt_full);
                        meas_valid <= 1'b1;
                        gate_cnt   <= '0;
                        edge_cnt   <= '0;
                        sat        <= 1'b0;
                        if (!en) begin
                            state <= IDLE;
                        end
                    end else if (!en) begin
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        sat      <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        gate_cnt <= gate_cnt + GATE_ONE;
                        if (pulse_edge) begin
                            if (cnt_full) begin
                                sat <= 1'b1;
                            end else begin
                                edge_cnt <= edge_cnt + CNT_ONE;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef PERIOD_MEAS_EN
    logic [31:0] period_ctr;
    logic        armed;

    // The first edge after IDLE only arms the counter, so no bogus period is reported.
    always_ff @(posedge clk) begin
        if (!reset) begin
            period_ctr   <= '0;
            armed        <= 1'b0;
            period_cyc   <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (state == IDLE) begin
                period_ctr <= '0;
                armed      <= 1'b0;
            end else if (pulse_edge) begin
                if (armed) begin
                    period_cyc   <= (period_ctr == 32'hFFFF_FFFF) ? period_ctr : period_ctr + 32'd1;
                    period_valid <= 1'b1;
                end
                period_ctr <= '0;
                armed      <= 1'b1;
            end else if (period_ctr != 32'hFFFF_FFFF) begin
                period_ctr <= period_ctr + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pulse_freq_meter.sv
// Directed bench for pulse_freq_meter with a 1000-cycle gate and a 4-bit counter.
`timescale 1ns/1ps

module tb_pulse_freq_meter;

    localparam int GATE   = 1000;
    localparam int CNT_W  = 4;
    localparam int GATE_W = 10;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             en = 1'b0;
    logic             pulse_in = 1'b0;
    logic [CNT_W-1:0] freq_cnt;
    logic             meas_valid;
    logic             ovf;
`ifdef PERIOD_MEAS_EN
    logic [31:0]      period_cyc;
    logic             period_valid;
`endif

    typedef struct {
        int t;
        int cnt;
        int ov;
    } strobe_t;

    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    int      base = 0;
    bit      hold = 1'b0;
    bit      pulse_map [4096];
    strobe_t sq [$];
    int      pq [$];

    pulse_freq_meter #(
        .GATE_CYCLES(GATE),
        .CNT_W      (CNT_W),
        .GATE_W     (GATE_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .pulse_in    (pulse_in),
        .freq_cnt    (freq_cnt),
        .meas_valid  (meas_valid),
        .ovf         (ovf)
`ifdef PERIOD_MEAS_EN
        ,
        .period_cyc  (period_cyc),
        .period_valid(period_valid)
`endif
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobes are captured on the falling edge, time-stamped with the cycle count.
    always @(negedge clk) begin
        if (meas_valid) sq.push_back('{cyc, int'(freq_cnt), int'(ovf)});
`ifdef PERIOD_MEAS_EN
        if (period_valid) pq.push_back(int'(period_cyc));
`endif
    end

    task automatic check_output(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic check_strobe(input string tag, input int idx, input int t, input int cnt, input int ov);
        if (idx < sq.size()) begin
            check_output({tag, "_time"}, sq[idx].t - base, t);
            check_output({tag, "_cnt"}, sq[idx].cnt, cnt);
            check_output({tag, "_ovf"}, sq[idx].ov, ov);
        end else begin
            check_output({tag, "_missing"}, -1, t);
        end
    endtask

    task automatic clear_map();
        foreach (pulse_map[i]) pulse_map[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            en       = 1'b0;
            reset    = 1'b1;
            pulse_in = hold;
        end
    endtask

    task automatic apply_stimulus(input int n, input int en_off, input int rst_step);
        sq.delete();
        pq.delete();
        for (int j = 0; j < n; j++) begin
            @(posedge clk); #1;
            if (j == 0) base = cyc;
            en       = (en_off < 0) || (j < en_off);
            reset    = (j != rst_step);
            pulse_in = hold | pulse_map[j];
            if (rst_step >= 0 && j == rst_step + 1) begin
                check_output("after_reset_freq", int'(freq_cnt), 0);
                check_output("after_reset_ovf", int'(ovf), 0);
                check_output("after_reset_valid", int'(meas_valid), 0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_freq", int'(freq_cnt), 0);
        check_output("reset_valid", int'(meas_valid), 0);
        check_output("reset_ovf", int'(ovf), 0);
`ifdef PERIOD_MEAS_EN
        check_output("reset_period", int'(period_cyc), 0);
        check_output("reset_pvalid", int'(period_valid), 0);
`endif
        idle(2);

        // Steady train, one pulse every 100 clocks.
        clear_map();
        for (int j = 0; j <= 3000; j += 100) pulse_map[j] = 1'b1;
        apply_stimulus(3010, -1, -1);
        idle(5);
        check_output("steady_n", sq.size(), 3);
        for (int k = 0; k < 3; k++) check_strobe("steady", k, 1001 + 1000 * k, 10, 0);
`ifdef PERIOD_MEAS_EN
        check_output("period_n", pq.size(), 30);
        foreach (pq[i]) check_output("period_val", pq[i], 100);
`endif

        // Input held high: the only rising edge happens while idle.
        hold = 1'b1;
        idle(5);
        clear_map();
        apply_stimulus(2010, -1, -1);
        idle(5);
        hold = 1'b0;
        idle(5);
        check_output("quiet_n", sq.size(), 2);
        check_strobe("quiet0", 0, 1001, 0, 0);
        check_strobe("quiet1", 1, 2001, 0, 0);

        // Single edge landing on the last gate cycle.
        clear_map();
        pulse_map[998] = 1'b1;
        apply_stimulus(2010, -1, -1);
        idle(5);
        check_output("bound_n", sq.size(), 2);
        check_strobe("bound0", 0, 1001, 1, 0);
        check_strobe("bound1", 1, 2001, 0, 0);

        // 20 edges saturate the 4-bit counter, then 5 edges.
        clear_map();
        for (int j = 10; j < 50; j += 2) pulse_map[j] = 1'b1;
        for (int j = 1100; j <= 1500; j += 100) pulse_map[j] = 1'b1;
        apply_stimulus(2010, -1, -1);
        idle(5);
        check_output("ovf_n", sq.size(), 2);
        check_strobe("ovf0", 0, 1001, 15, 1);
        check_strobe("ovf1", 1, 2001, 5, 0);

        // One-cycle reset at gate_cnt 500 with en held high.
        clear_map();
        for (int j = 50; j < 1600; j += 100) pulse_map[j] = 1'b1;
        apply_stimulus(1510, -1, 501);
        idle(5);
        check_output("rstmid_n", sq.size(), 1);
        check_strobe("rstmid", 0, 1503, 10, 0);

        // en dropped at gate_cnt 300: nothing latched.
        apply_stimulus(1100, 301, -1);
        idle(5);
        check_output("endrop_n", sq.size(), 0);
        check_output("endrop_freq", int'(freq_cnt), 10);
        check_output("endrop_ovf", int'(ovf), 0);

        // en dropped on the window-end cycle: window still completes.
        clear_map();
        for (int j = 50; j < 700; j += 100) pulse_map[j] = 1'b1;
        apply_stimulus(1100, 1000, -1);
        idle(5);
        check_output("enend_n", sq.size(), 1);
        check_strobe("enend", 0, 1001, 7, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
